// File: rtl/oct_pkg.sv
// Shared definitions for the pixel streamer: FSM state encoding and
// default parameter values.
package oct_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_IMG_PIXELS    = 1024;
  localparam int DEF_ADDR_WIDTH    = 16;
  localparam int DEF_DRAIN_TIMEOUT = 16;

endpackage

// File: rtl/frame_addr_counter.sv
// Frame address counter: synchronous clear, count enable, and a flag
// that is high while the count equals LIMIT.
module frame_addr_counter #(
  parameter int WIDTH = 16,
  parameter int LIMIT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             term
);

  // count register; clear wins over enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     count <= '0;
    else if (clr)  count <= '0;
    else if (en)   count <= count + 1'b1;
  end

  assign term = (count == WIDTH'(LIMIT));

endmodule

// File: rtl/oct_pixel_streamer.sv
// Streams one frame from a source buffer through an enhancement block
// into a result buffer. Reads have one cycle of latency; pixel_in is
// registered, so a read issued at cycle N emits at N+2.
// Optional running checksum of written results: define STREAMER_CHECKSUM_EN.
module oct_pixel_streamer
  import oct_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int IMG_PIXELS    = DEF_IMG_PIXELS,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stall,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] pixel_in,
  output logic                  pixel_valid,
  input  logic [DATA_WIDTH-1:0] pixel_out,
  input  logic                  pixel_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [15:0]           checksum
);

  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

  state_t                state, nxt;
  logic [ADDR_WIDTH-1:0] iss_cnt, res_cnt;
  logic                  iss_last, res_full;
  logic                  go, issue, accept, timeout;
  logic [TW-1:0]         tmr;
  logic [2:1]            vld_pipe;

  assign go      = (state == IDLE) && start;
  assign busy    = (state == ISSUE) || (state == DRAIN);
  assign issue   = (state == ISSUE) && !stall;
  // res_full gate keeps the result counter from running past the frame
  assign accept  = busy && pixel_ready && !res_full;
  assign timeout = (state == DRAIN) && !pixel_ready && (tmr == TW'(DRAIN_TIMEOUT - 1));
  assign done    = (state == DONE);
  assign rd_en   = issue;
  assign rd_addr = issue ? iss_cnt : '0;

  frame_addr_counter #(.WIDTH(ADDR_WIDTH), .LIMIT(IMG_PIXELS - 1)) u_iss_cnt (
    .clk(clk), .reset(reset), .clr(go), .en(issue), .count(iss_cnt), .term(iss_last)
  );

  frame_addr_counter #(.WIDTH(ADDR_WIDTH), .LIMIT(IMG_PIXELS)) u_res_cnt (
    .clk(clk), .reset(reset), .clr(go), .en(accept), .count(res_cnt), .term(res_full)
  );

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // next-state: completion takes priority over the drain timeout
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (go) nxt = ISSUE;
      ISSUE: if (issue && iss_last) nxt = DRAIN;
      DRAIN: if (res_full || timeout) nxt = DONE;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // read-to-pixel pipeline: stage 1 is data-return, stage 2 is pixel_in
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      pixel_in <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], issue};
      if (vld_pipe[1]) pixel_in <= rd_data;
    end
  end

  assign pixel_valid = vld_pipe[2];

  // result write port, one cycle behind each accepted result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_addr <= res_cnt;
        wr_data <= pixel_out;
      end
    end
  end

  // cycles since the last pixel_ready; only counts up while draining
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                tmr <= '0;
    else if (pixel_ready)     tmr <= TW'(1);
    else if (state == DRAIN) begin
      if (tmr != TW'(DRAIN_TIMEOUT)) tmr <= tmr + 1'b1;
    end else                  tmr <= '0;
  end

  // sticky timeout flag, cleared by the next accepted start
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     err <= 1'b0;
    else if (go)                   err <= 1'b0;
    else if (timeout && !res_full) err <= 1'b1;
  end

`ifdef STREAMER_CHECKSUM_EN
  logic [15:0] csum;

  // running mod-2^16 sum of written results
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      csum <= '0;
    else if (go)    csum <= '0;
    else if (wr_en) csum <= csum + 16'(wr_data);
  end

  assign checksum = csum;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_oct_pixel_streamer.sv
// Self-checking bench for oct_pixel_streamer (IMG_PIXELS=4).
// Downstream model is a negative transform answering in the same cycle.
module tb_oct_pixel_streamer;

  localparam int DW   = 8;
  localparam int AW   = 16;
  localparam int NPIX = 4;
  localparam int TMO  = 16;

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0, stall = 1'b0;
  logic [AW-1:0] rd_addr, wr_addr;
  logic          rd_en, pixel_valid, pixel_ready, wr_en, busy, done, err;
  logic [DW-1:0] rd_data = '0, pixel_in, pixel_out, wr_data;
  logic [15:0]   checksum;

  int checks = 0, errors = 0;
  int cyc = 0, last_rdy = 0, done_cnt = 0, pv_seen = 0;
  logic hold_last = 1'b0;
  logic [DW-1:0] mem [NPIX];

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t sb[$];
  wr_t e;

  // index 0 of src/exp is the rightmost byte
  typedef struct packed {
    logic [3:0][7:0] src;
    logic [3:0][7:0] exp;
    logic [15:0]     sum;
    logic [15:0]     stall_mask;
    logic [7:0]      restart;
  } vec_t;
  vec_t vecs[3];

  oct_pixel_streamer #(.DATA_WIDTH(DW), .IMG_PIXELS(NPIX), .ADDR_WIDTH(AW),
                       .DRAIN_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .pixel_out(pixel_out), .pixel_ready(pixel_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err), .checksum(checksum)
  );

  always #5 clk = ~clk;

  // source buffer with one-cycle read latency; downstream pixel counter
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) rd_data <= mem[rd_addr[1:0]];
    if (start) pv_seen <= 0;
    else if (pixel_valid) pv_seen <= pv_seen + 1;
  end

  assign pixel_out   = ~pixel_in;
  assign pixel_ready = pixel_valid && !(hold_last && pv_seen == NPIX - 1);

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, a, x);
    end
  endtask

  function automatic logic [15:0] xsum(input logic [15:0] s);
`ifdef STREAMER_CHECKSUM_EN
    return s;
`else
    return 16'h0000;
`endif
  endfunction

  // scoreboard: pop an expected write for every wr_en
  always @(negedge clk) begin
    if (!reset) begin
      if (pixel_ready) last_rdy = cyc;
      if (done) done_cnt++;
      if (wr_en) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_extra actual addr=%0h data=%0h required none", wr_addr, wr_data);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", 128'(wr_addr), 128'(e.addr));
          chk("wr_data", 128'(wr_data), 128'(e.data));
        end
      end
    end
  end

  task automatic run_frame(input vec_t v, input logic [15:0] exp_sum);
    int iss, d0, dcyc, nwr;
    bit got;
    iss = 0; got = 0; dcyc = 0;
    nwr = hold_last ? NPIX - 1 : NPIX;
    for (int i = 0; i < NPIX; i++) mem[i] = v.src[i];
    for (int i = 0; i < nwr; i++) sb.push_back({AW'(i), v.exp[i]});
    d0 = done_cnt;
    @(negedge clk); start = 1'b1;
    for (int c = 1; c <= 20 && iss < NPIX; c++) begin
      @(negedge clk);
      start = (c == int'(v.restart));
      stall = v.stall_mask[c];
      #1;
      if (c == 1) chk("busy_issue", 128'(busy), 128'(1));
      chk("rd_en", 128'(rd_en), 128'(!stall));
      if (!stall) begin
        chk("rd_addr", 128'(rd_addr), 128'(iss));
        iss++;
      end
    end
    start = 1'b0;
    stall = 1'b0;
    if (iss < NPIX) chk("issue_count", 128'(iss), 128'(NPIX));
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (done) begin got = 1; dcyc = cyc; end
    end
    chk("done_seen", 128'(got), 128'(1));
    if (hold_last) chk("tmo_distance", 128'(dcyc - last_rdy), 128'(TMO));
    repeat (3) @(negedge clk);
    chk("done_pulses", 128'(done_cnt - d0), 128'(1));
    chk("sb_empty", 128'(sb.size()), 128'(0));
    chk("checksum", 128'(checksum), 128'(xsum(exp_sum)));
    chk("busy_after", 128'(busy), 128'(0));
    chk("err", 128'(err), 128'(hold_last));
    sb.delete();
  endtask

  initial begin
    vecs[0].src = {8'hFF, 8'h80, 8'h10, 8'h00};
    vecs[0].exp = {8'h00, 8'h7F, 8'hEF, 8'hFF};
    vecs[0].sum = 16'h026D; vecs[0].stall_mask = 16'h0000; vecs[0].restart = 8'd0;
    vecs[1].src = {8'h04, 8'h03, 8'h02, 8'h01};
    vecs[1].exp = {8'hFB, 8'hFC, 8'hFD, 8'hFE};
    vecs[1].sum = 16'h03F2; vecs[1].stall_mask = 16'b0000_0000_0001_1100; vecs[1].restart = 8'd0;
    vecs[2].src = {8'h0F, 8'hF0, 8'h55, 8'hAA};
    vecs[2].exp = {8'hF0, 8'h0F, 8'hAA, 8'h55};
    vecs[2].sum = 16'h01FE; vecs[2].stall_mask = 16'h0000; vecs[2].restart = 8'd2;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", 128'({rd_en, rd_addr, pixel_in, pixel_valid, wr_en, wr_addr,
                               wr_data, busy, done, err, checksum}), 128'(0));
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_reset", 128'({busy, rd_en}), 128'(0));

    for (int i = 0; i < 3; i++) run_frame(vecs[i], vecs[i].sum);

    // last pixel withheld: 0xFF+0xEF+0x7F written, the 0x00 never is
    hold_last = 1'b1;
    run_frame(vecs[0], 16'h026D);
    hold_last = 1'b0;
    repeat (4) @(negedge clk);
    chk("err_sticky", 128'(err), 128'(1));

    // reset in the middle of ISSUE
    for (int i = 0; i < NPIX; i++) mem[i] = vecs[0].src[i];
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    #1;
    chk("err_clr_on_start", 128'(err), 128'(0));
    chk("busy_mid", 128'(busy), 128'(1));
    @(negedge clk); reset = 1'b1;
    #1;
    chk("mid_reset_outputs", 128'({rd_en, rd_addr, pixel_in, pixel_valid, wr_en, wr_addr,
                                   wr_data, busy, done, err, checksum}), 128'(0));
    @(negedge clk); reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("idle_post_reset", 128'({busy, pixel_valid, rd_en}), 128'(0));
    run_frame(vecs[0], vecs[0].sum);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
